// File: rtl/control_carro.sv
// control_carro: car sequencer. Spawns a car at the top of one of four lanes,
// issues load/step/park pulses and raises the speed level as cars are cleared.
//
// Ports:
//   iClk, iReset (async, active high)
//   iStart (level), iPausa (level), iCuenta (pulse), iColision (pulse)
//   oPosicionX/Y    spawn coordinates, valid while oEnable = 1
//   oPosicionAuxX/Y parking coordinates (constant)
//   oEnable / oResta / oSalto  one-cycle load / step / park pulses
//   oNivel          speed level 0..3
//   oActivo         high while a car is loading, running or waiting
//
// Build option: LFSR_LANE_EN selects lanes from the LFSR (never repeating the
// previous lane). Without it lanes go round-robin starting at lane 0.
module control_carro #(
   parameter int DIV_BASE         = 208333,
   parameter int CARROS_POR_NIVEL = 8,
   parameter int SPAWN_GAP        = 25000000,
   parameter int CARRIL_X0        = 200,
   parameter int CARRIL_PASO      = 64,
   parameter int PARK_X           = 0,
   parameter int PARK_Y           = 500
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic       iStart,
   input  logic       iPausa,
   input  logic       iCuenta,
   input  logic       iColision,
   output logic [9:0] oPosicionX,
   output logic [8:0] oPosicionY,
   output logic [9:0] oPosicionAuxX,
   output logic [8:0] oPosicionAuxY,
   output logic       oEnable,
   output logic       oResta,
   output logic       oSalto,
   output logic [1:0] oNivel,
   output logic       oActivo
);

   localparam int CW = $clog2(CARROS_POR_NIVEL + 1);

   typedef enum logic [2:0] {IDLE, CARGA, CORRE, ESPERA, FIN} state_t;

   state_t        state_q, state_d;
   logic [24:0]   div_q, div_d;
   logic [24:0]   gap_q, gap_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    nivel_q, nivel_d;
   logic [9:0]    posx_q, posx_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic          enable_q, enable_d;
   logic          resta_q, resta_d;
   logic          salto_q, salto_d;
   logic          activo_q, activo_d;
`ifdef LFSR_LANE_EN
   logic [1:0]    prev_q, prev_d;
   logic          prev_vld_q, prev_vld_d;
`else
   logic [1:0]    lane_q, lane_d;
`endif

   logic [24:0]   period;
   logic [1:0]    lane_sel;

   // Period follows the level; levels only change while the divider is idle.
   assign period = 25'(DIV_BASE) >> nivel_q;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      gap_d      = gap_q;
      cnt_d      = cnt_q;
      nivel_d    = nivel_q;
      posx_d     = posx_q;
      enable_d   = 1'b0;
      resta_d    = 1'b0;
      salto_d    = 1'b0;
      activo_d   = (state_q == CARGA) || (state_q == CORRE) || (state_q == ESPERA);
      lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      lane_sel   = 2'd0;
`ifdef LFSR_LANE_EN
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
`else
      lane_d     = lane_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (iStart) begin
               state_d = CARGA;
`ifndef LFSR_LANE_EN
               lane_d  = 2'd0;
`endif
            end
         end
         CARGA: begin
`ifdef LFSR_LANE_EN
            lane_sel = lfsr_q[1:0];
            if (prev_vld_q && (lane_sel == prev_q))
               lane_sel = lane_sel + 2'd1;
            prev_d     = lane_sel;
            prev_vld_d = 1'b1;
`else
            lane_sel = lane_q;
            lane_d   = lane_q + 2'd1;
`endif
            enable_d = 1'b1;
            posx_d   = 10'(CARRIL_X0 + int'(lane_sel) * CARRIL_PASO);
            div_d    = '0;
            state_d  = CORRE;
         end
         CORRE: begin
            if (iColision) begin
               // collision beats a simultaneous clear; no step after this edge
               salto_d = 1'b1;
               state_d = FIN;
            end else if (iCuenta) begin
               cnt_d   = cnt_q + 1'b1;
               gap_d   = '0;
               state_d = ESPERA;
            end else if (!iPausa) begin
               if (div_q >= period - 25'd1) begin
                  div_d   = '0;
                  resta_d = 1'b1;
               end else begin
                  div_d = div_q + 25'd1;
               end
            end
         end
         ESPERA: begin
            // level bookkeeping lands one cycle after the clear
            if (cnt_q == CW'(CARROS_POR_NIVEL)) begin
               cnt_d = '0;
               if (nivel_q != 2'd3) nivel_d = nivel_q + 2'd1;
            end
            if (!iPausa) begin
               if (gap_q == 25'(SPAWN_GAP - 1)) state_d = CARGA;
               else                             gap_d   = gap_q + 25'd1;
            end
         end
         FIN: begin
            if (iStart) begin
               state_d = CARGA;
               nivel_d = 2'd0;
               cnt_d   = '0;
               div_d   = '0;
`ifndef LFSR_LANE_EN
               lane_d  = 2'd0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state_q    <= IDLE;
         div_q      <= '0;
         gap_q      <= '0;
         cnt_q      <= '0;
         nivel_q    <= '0;
         posx_q     <= '0;
         lfsr_q     <= 8'hA5;
         enable_q   <= 1'b0;
         resta_q    <= 1'b0;
         salto_q    <= 1'b0;
         activo_q   <= 1'b0;
`ifdef LFSR_LANE_EN
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
`else
         lane_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         gap_q      <= gap_d;
         cnt_q      <= cnt_d;
         nivel_q    <= nivel_d;
         posx_q     <= posx_d;
         lfsr_q     <= lfsr_d;
         enable_q   <= enable_d;
         resta_q    <= resta_d;
         salto_q    <= salto_d;
         activo_q   <= activo_d;
`ifdef LFSR_LANE_EN
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
`else
         lane_q     <= lane_d;
`endif
      end
   end

   assign oPosicionX    = posx_q;
   assign oPosicionY    = 9'd0;
   assign oPosicionAuxX = 10'(PARK_X);
   assign oPosicionAuxY = 9'(PARK_Y);
   assign oEnable       = enable_q;
   assign oResta        = resta_q;
   assign oSalto        = salto_q;
   assign oNivel        = nivel_q;
   assign oActivo       = activo_q;

endmodule

// File: tb/tb_control_carro.sv
module tb_control_carro;
   localparam int DB = 16, CPN = 2, SG = 4;

   logic iClk = 1'b0, iReset = 1'b1, iStart = 1'b0, iPausa = 1'b0;
   logic iCuenta = 1'b0, iColision = 1'b0;
   logic [9:0] oPosicionX, oPosicionAuxX;
   logic [8:0] oPosicionY, oPosicionAuxY;
   logic oEnable, oResta, oSalto, oActivo;
   logic [1:0] oNivel;

   control_carro #(.DIV_BASE(DB), .CARROS_POR_NIVEL(CPN), .SPAWN_GAP(SG)) dut (
      .iClk(iClk), .iReset(iReset), .iStart(iStart), .iPausa(iPausa),
      .iCuenta(iCuenta), .iColision(iColision),
      .oPosicionX(oPosicionX), .oPosicionY(oPosicionY),
      .oPosicionAuxX(oPosicionAuxX), .oPosicionAuxY(oPosicionAuxY),
      .oEnable(oEnable), .oResta(oResta), .oSalto(oSalto),
      .oNivel(oNivel), .oActivo(oActivo));

   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   int nvec = 0, nerr = 0, mutex_viol = 0;
   always @(negedge iClk)
      if (int'(oEnable) + int'(oResta) + int'(oSalto) > 1) mutex_viol++;

   // reference model: cleared cars since (re)start, spawn count, last lane X
   int clears = 0, spawn_idx = 0, prev_x = 0, prev_vld = 0, t_en = 0;

   function automatic int lvl();
      return (clears / CPN > 3) ? 3 : clears / CPN;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge iClk);
   endtask

   // sel: 0 oEnable, 1 oResta, 2 oSalto
   task automatic wait_sig(input int sel, input int limit, output int t);
      t = -1;
      for (int i = 0; i < limit; i++) begin
         tick();
         if ((sel == 0 && oEnable) || (sel == 1 && oResta) || (sel == 2 && oSalto)) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk("timeout", t, limit);
   endtask

   task automatic check_spawn();
      int x;
      x = int'(oPosicionX);
`ifdef LFSR_LANE_EN
      chk("lane_set", int'(x == 200 || x == 264 || x == 328 || x == 392), 1);
      if (prev_vld != 0) chk("lane_repeat", int'(x == prev_x), 0);
`else
      chk("lane_x", x, 200 + 64 * (spawn_idx % 4));
`endif
      spawn_idx++;
      prev_x = x;
      prev_vld = 1;
      chk("pos_y", int'(oPosicionY), 0);
      chk("activo_spawn", int'(oActivo), 1);
      chk("nivel_spawn", int'(oNivel), lvl());
      tick();
      chk("enable_width", int'(oEnable), 0);
   endtask

   task automatic start_game();
      int k, t;
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      k = cyc;
      clears = 0;
      spawn_idx = 0;
      wait_sig(0, 10, t);
      chk("start_latency", t - k, 1);
      t_en = t;
      check_spawn();
   endtask

   // kind: 0 clear, 1 collision, 2 both; lc/le < 0 pick a random pause length
   task automatic run_car(input int nsteps, input int kind, input int lc, input int le);
      int p, prev, t, L, k, quiet;
      p = DB >> lvl();
      prev = t_en;
      for (int s = 0; s < nsteps; s++) begin
         L = (lc >= 0) ? ((s == 0) ? lc : 0)
                       : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0);
         if (L > 0) begin
            iPausa = 1'b1;
            repeat (L) tick();
            iPausa = 1'b0;
         end
         wait_sig(1, 300, t);
         chk("step_interval", t - prev, p + L);
         prev = t;
      end
      iCuenta   = (kind != 1);
      iColision = (kind != 0);
      tick();
      iCuenta   = 1'b0;
      iColision = 1'b0;
      k = cyc;
      if (kind == 0) begin
         clears++;
         tick();
         chk("nivel_update", int'(oNivel), lvl());
         L = (le >= 0) ? le : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0);
         if (L > 0) begin
            iPausa = 1'b1;
            repeat (L) tick();
            iPausa = 1'b0;
         end
         wait_sig(0, 300, t);
         chk("spawn_gap", t - k, SG + 1 + L);
         t_en = t;
         check_spawn();
      end else begin
         chk("salto", int'(oSalto), 1);
         chk("nivel_on_col", int'(oNivel), lvl());
         tick();
         chk("salto_width", int'(oSalto), 0);
         chk("activo_fin", int'(oActivo), 0);
         quiet = 0;
         repeat (40) begin
            tick();
            quiet += int'(oEnable) + int'(oResta) + int'(oSalto);
         end
         chk("fin_quiet", quiet, 0);
         start_game();
         chk("nivel_restart", int'(oNivel), 0);
      end
   endtask

   initial begin
      int quiet, r;
      repeat (3) tick();
      chk("rst_enable", int'(oEnable), 0);
      chk("rst_resta", int'(oResta), 0);
      chk("rst_salto", int'(oSalto), 0);
      chk("rst_nivel", int'(oNivel), 0);
      chk("rst_posx", int'(oPosicionX), 0);
      chk("rst_activo", int'(oActivo), 0);
      chk("aux_x", int'(oPosicionAuxX), 0);
      chk("aux_y", int'(oPosicionAuxY), 500);
      iReset = 1'b0;
      quiet = 0;
      repeat (20) begin
         tick();
         quiet += int'(oEnable) + int'(oActivo);
      end
      chk("idle_hold", quiet, 0);

      start_game();
      run_car(2, 0, 100, 100);          // long pauses in CORRE and ESPERA
      for (int i = 0; i < 6; i++) run_car(2, 0, 0, 0);  // levels 1..3 and saturation
      run_car(1, 2, 0, 0);              // simultaneous clear and collision
      for (int i = 0; i < 70; i++) begin
         r = int'($urandom_range(0, 9));
         run_car(int'($urandom_range(1, 3)), (r < 8) ? 0 : ((r == 8) ? 1 : 2), -1, -1);
      end

      // asynchronous reset in the middle of a run
      repeat (3) tick();
      iReset = 1'b1;
      #1;
      chk("arst_enable", int'(oEnable), 0);
      chk("arst_resta", int'(oResta), 0);
      chk("arst_salto", int'(oSalto), 0);
      chk("arst_nivel", int'(oNivel), 0);
      chk("arst_posx", int'(oPosicionX), 0);
      chk("arst_activo", int'(oActivo), 0);
      clears = 0;
      spawn_idx = 0;
      prev_vld = 0;
      repeat (2) tick();
      iReset = 1'b0;
      quiet = 0;
      repeat (30) begin
         tick();
         quiet += int'(oEnable) + int'(oResta) + int'(oActivo);
      end
      chk("arst_idle", quiet, 0);
      start_game();
      run_car(1, 0, 0, 0);

      chk("mutex", mutex_viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/control_carro.md
# control_carro

Sequencer directly upstream of the car object. It spawns each car at the top of a lane chosen by an LFSR, issues the load, step and park pulses that move it, and raises the speed level as cars are cleared. It consumes the car's end-of-screen pulse and the collision flag, and drives the car's load/step/jump inputs and coordinate buses.

## Interface
Parameters:
- DIV_BASE, 208333: clock cycles per step at level 0 (~240 px/s at 50 MHz); minimum 16.
- CARROS_POR_NIVEL, 8: cleared cars per level increment.
- SPAWN_GAP, 25000000: idle cycles between a car clearing and the next spawn.
- CARRIL_X0, 200: X of lane 0.
- CARRIL_PASO, 64: X spacing between lanes (4 lanes).
- PARK_X, 0 / PARK_Y, 500: parking coordinates used on collision.

Ports:
- iClk  in  1  system clock, single domain.
- iReset  in  1  asynchronous, active-high reset.
- iStart  in  1  level; starts or restarts a game.
- iPausa  in  1  level; freezes all timing.
- iCuenta  in  1  one-cycle pulse: car Y reached 480.
- iColision  in  1  one-cycle pulse: car hit player.
- oPosicionX  out  10  spawn X, valid while oEnable = 1.
- oPosicionY  out  9  spawn Y, always 0.
- oPosicionAuxX  out  10  constant PARK_X.
- oPosicionAuxY  out  9  constant PARK_Y.
- oEnable  out  1  one-cycle load pulse.
- oResta  out  1  one-cycle step pulse (Y+1).
- oSalto  out  1  one-cycle park pulse.
- oNivel  out  2  speed level 0..3.
- oActivo  out  1  high in CARGA, CORRE and ESPERA.

## Operation
- States: IDLE, CARGA, CORRE, ESPERA, FIN. All outputs are registered.
- Reset forces the following, mid-game included:
  - state IDLE and all pulses 0;
  - oNivel 0, oPosicionX 0 and oActivo 0;
  - divider, gap counter and cleared-car counter 0;
  - LFSR 8'hA5.
- IDLE: iStart=1 -> CARGA.
- CARGA lasts one cycle.
  - oEnable=1 and oPosicionX = CARRIL_X0 + lane*CARRIL_PASO.
  - oResta and oSalto are guaranteed 0.
  - Next state: CORRE, with the divider cleared.
- CORRE, step timing:
  - The divider counts while iPausa=0.
  - When it reaches period-1, oResta=1 for one cycle and the divider wraps to 0.
  - period = DIV_BASE >> oNivel.
- CORRE, events:
  - iColision: oSalto=1 for the next cycle, then FIN.
  - iCuenta: cleared counter +1, then ESPERA.
  - If the counter reaches CARROS_POR_NIVEL, it clears and oNivel increments, saturating at 3.
  - iColision and iCuenta in the same cycle: collision wins and nothing is counted.
- ESPERA: the gap counter runs while iPausa=0. After SPAWN_GAP cycles -> CARGA. iColision is ignored.
- FIN: holds. iStart -> CARGA, with oNivel, the cleared counter and the divider cleared.
- iStart outside IDLE and FIN is ignored.
- LFSR: 8-bit Fibonacci with taps 8,6,5,4. It shifts every clock and is never paused; lane selection is defined under Configuration.
- Counter widths:
  - divider and gap counter: 25 bits;
  - cleared counter: ceil(log2(CARROS_POR_NIVEL+1)) bits.

## Timing
- iStart sampled at edge k in IDLE: oEnable is high from edge k+1 to edge k+2.
- First oResta: exactly period cycles after the oEnable cycle (no pause).
- iColision sampled at edge k: oSalto is high for exactly cycle k+1. No oResta after edge k.
- iCuenta sampled at edge k: oNivel updates at edge k+1. The next oEnable follows SPAWN_GAP+1 cycles later.
- Pause freezes counters in place. On release, counting resumes from the held value with no extra pulse.
- A level change takes effect from the divider's next wrap.
- Never asserted together: oEnable, oResta and oSalto (mutually exclusive).

## Configuration
- LFSR_LANE_EN defined:
  - lane = LFSR[1:0] sampled in CARGA;
  - if lane equals the previous lane, (lane+1) mod 4 is used instead.
- LFSR_LANE_EN undefined:
  - lanes are round-robin 0,1,2,3,0,…;
  - the first spawn after reset or restart is lane 0;
  - the LFSR is still present but unused.

## Test plan
All scenarios use DIV_BASE=16, CARROS_POR_NIVEL=2, SPAWN_GAP=4.
- Reset then iStart pulse:
  - oEnable high for 1 cycle, with oPosicionY=0 and oPosicionX a lane in {200,264,328,392};
  - oResta every 16 cycles; oActivo=1.
- Round-robin build, four clears via iCuenta: spawn X sequence is 200, 264, 328, 392.
- With LFSR_LANE_EN, 64 clears: no two consecutive spawns share an X.
- iCuenta twice:
  - oNivel=1 and the oResta period becomes 8;
  - 4 more clears give oNivel=3, period 2, which saturates there.
- iCuenta and iColision in the same cycle:
  - oSalto is 1 for one cycle, the state is FIN, oNivel is unchanged, and oResta/oEnable stop;
  - then iStart gives oEnable with oNivel=0.
- Pauses:
  - iPausa held 100 cycles mid-CORRE: no oResta, and the step interval is stretched by exactly 100 cycles.
  - iPausa held during ESPERA: the gap is stretched by the same amount.
- iReset asserted mid-CORRE: all outputs 0 immediately (async), and the block stays in IDLE until iStart.
